// File: rtl/mem_line_initiator_pkg.sv
// mem_if_pkg: shared definitions for the main-memory line initiator.
//   - state encoding of the transaction FSM
//   - line / byte-enable / address widths
//   - requester identifiers used by the arbiter and the owner register
//   - helper that decides when the write strobes may be active
package mem_if_pkg;

    localparam int LINE_BITS = 128;
    localparam int BE_BITS   = 16;
    localparam int LINE_AW   = 11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Value doubles as the bit index inside the arbiter request/grant vectors.
    typedef enum logic {
        REQ_IC = 1'b0,
        REQ_DC = 1'b1
    } req_id_e;

    // Write strobes skip the first access cycle (address setup) and the last
    // one (hold), so they are only active strictly between 0 and last.
    function automatic logic wr_window(input logic [3:0] cnt, input logic [3:0] last);
        return (cnt != 4'd0) && (cnt != last);
    endfunction

endpackage

// File: rtl/mem_line_initiator_if.sv
// mem_line_initiator_if: cache-side request/ack signals plus memory-side strobes.
//   master modport : the initiator (drives ACKs, RDATA, BUSY and memory strobes)
//   slave modport  : the environment (caches and memory array)
interface mem_line_initiator_if;
    import mem_if_pkg::*;

    logic                 IC_REQ;
    logic [LINE_AW-1:0]   IC_ADDR;
    logic                 IC_ACK;
    logic                 DC_REQ;
    logic                 DC_WE;
    logic [LINE_AW-1:0]   DC_ADDR;
    logic [BE_BITS-1:0]   DC_BE;
    logic [LINE_BITS-1:0] DC_WDATA;
    logic                 DC_ACK;
    logic [LINE_BITS-1:0] RDATA;
    logic                 BUSY;
    logic [LINE_AW-1:0]   MEM_A;
    logic                 MEM_CE;
    logic                 MEM_OE_N;
    logic [BE_BITS-1:0]   MEM_WR_N;
    logic [LINE_BITS-1:0] MEM_DOUT;
    logic [LINE_BITS-1:0] MEM_DIN;

    modport master (
        input  IC_REQ, IC_ADDR, DC_REQ, DC_WE, DC_ADDR, DC_BE, DC_WDATA, MEM_DIN,
        output IC_ACK, DC_ACK, RDATA, BUSY, MEM_A, MEM_CE, MEM_OE_N, MEM_WR_N, MEM_DOUT
    );

    modport slave (
        output IC_REQ, IC_ADDR, DC_REQ, DC_WE, DC_ADDR, DC_BE, DC_WDATA, MEM_DIN,
        input  IC_ACK, DC_ACK, RDATA, BUSY, MEM_A, MEM_CE, MEM_OE_N, MEM_WR_N, MEM_DOUT
    );

endinterface

// File: rtl/mem_line_initiator_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter.
//   clk, rst_n : clock, async active-low reset (last grant resets to DCACHE)
//   req[1:0]   : requests, indexed by req_id_e
//   accept     : the grant is being taken this cycle; only then does the
//                last-grant pointer advance
//   gnt[1:0]   : one-hot grant (combinational)
module rr_arbiter2
    import mem_if_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    req_id_e last_q;
    req_id_e last_d;

    // Grant selection and pointer update
    always_comb begin
        gnt    = 2'b00;
        last_d = last_q;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_q == REQ_DC) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
        if (accept && (gnt != 2'b00)) begin
            last_d = gnt[REQ_DC] ? REQ_DC : REQ_IC;
        end else begin
            last_d = last_q;
        end
    end

    // Last-grant pointer; DCACHE after reset so ICACHE wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= REQ_DC;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_line_initiator.sv
// mem_line_initiator: main-memory line initiator for ICACHE and DCACHE.
//   CLK, CLR : clock (rising edge), async active-low reset
//   bus      : cache requests/acks, shared RDATA line buffer, BUSY and the
//              memory strobes (MEM_A, MEM_CE, MEM_OE_N, MEM_WR_N, MEM_DOUT,
//              MEM_DIN)
// A request is accepted in IDLE, held on the memory strobes for
// ACCESS_CYCLES cycles, and acknowledged with a one-cycle pulse in DONE.
// All outputs are flops so that reset clears the strobes without a clock.
module mem_line_initiator
    import mem_if_pkg::*;
#(
    parameter int ACCESS_CYCLES = 4
) (
    input  logic                   CLK,
    input  logic                   CLR,
    mem_line_initiator_if.master   bus
);

    localparam logic [3:0] CNT_LAST = 4'(ACCESS_CYCLES - 1);

    state_e               state_q,    state_d;
    logic [3:0]           cnt_q,      cnt_d;
    req_id_e              owner_q,    owner_d;
    logic                 we_q,       we_d;
    logic [BE_BITS-1:0]   be_q,       be_d;
    logic [LINE_AW-1:0]   mem_a_q,    mem_a_d;
    logic [LINE_BITS-1:0] mem_dout_q, mem_dout_d;
    logic [LINE_BITS-1:0] rdata_q,    rdata_d;
    logic                 ce_q,       ce_d;
    logic                 oe_n_q,     oe_n_d;
    logic [BE_BITS-1:0]   wr_n_q,     wr_n_d;
    logic                 ic_ack_q,   ic_ack_d;
    logic                 dc_ack_q,   dc_ack_d;
    logic                 busy_q,     busy_d;

    logic [1:0] req_s;
    logic [1:0] gnt_s;
    logic       accept_s;

    assign req_s = {bus.DC_REQ, bus.IC_REQ};

    rr_arbiter2 u_arb (
        .clk    (CLK),
        .rst_n  (CLR),
        .req    (req_s),
        .accept (accept_s),
        .gnt    (gnt_s)
    );

    // Next-state, transaction capture and next-cycle output values
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        we_d       = we_q;
        be_d       = be_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        rdata_d    = rdata_q;
        accept_s   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_s != 2'b00) begin
                    accept_s = 1'b1;
                    state_d  = ST_ACCESS;
                    cnt_d    = 4'd0;
                    if (gnt_s[REQ_DC]) begin
                        owner_d    = REQ_DC;
                        we_d       = bus.DC_WE;
                        be_d       = bus.DC_BE;
                        mem_a_d    = bus.DC_ADDR;
                        mem_dout_d = bus.DC_WDATA;
                    end else begin
                        // ICACHE only reads; MEM_DOUT keeps its last value
                        owner_d    = REQ_IC;
                        we_d       = 1'b0;
                        be_d       = 16'h0000;
                        mem_a_d    = bus.IC_ADDR;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    if (!we_q) begin
                        rdata_d = bus.MEM_DIN;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered, so they are derived from the next state
        ce_d     = (state_d == ST_ACCESS);
        oe_n_d   = !(ce_d && !we_d);
        wr_n_d   = (ce_d && we_d && wr_window(cnt_d, CNT_LAST)) ? ~be_d : 16'hFFFF;
        ic_ack_d = (state_d == ST_DONE) && (owner_d == REQ_IC);
        dc_ack_d = (state_d == ST_DONE) && (owner_d == REQ_DC);
        busy_d   = (state_d != ST_IDLE);
    end

    // State, transaction registers and output flops
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            owner_q    <= REQ_IC;
            we_q       <= 1'b0;
            be_q       <= 16'h0000;
            mem_a_q    <= 11'h000;
            mem_dout_q <= 128'h0;
            rdata_q    <= 128'h0;
            ce_q       <= 1'b0;
            oe_n_q     <= 1'b1;
            wr_n_q     <= 16'hFFFF;
            ic_ack_q   <= 1'b0;
            dc_ack_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            be_q       <= be_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            rdata_q    <= rdata_d;
            ce_q       <= ce_d;
            oe_n_q     <= oe_n_d;
            wr_n_q     <= wr_n_d;
            ic_ack_q   <= ic_ack_d;
            dc_ack_q   <= dc_ack_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.IC_ACK   = ic_ack_q;
    assign bus.DC_ACK   = dc_ack_q;
    assign bus.RDATA    = rdata_q;
    assign bus.BUSY     = busy_q;
    assign bus.MEM_A    = mem_a_q;
    assign bus.MEM_CE   = ce_q;
    assign bus.MEM_OE_N = oe_n_q;
    assign bus.MEM_WR_N = wr_n_q;
    assign bus.MEM_DOUT = mem_dout_q;

endmodule

// File: tb/tb_mem_line_initiator.sv
// Directed bench for mem_line_initiator: a default build (ACCESS_CYCLES=4)
// and a short build (ACCESS_CYCLES=3) sharing clock and reset.
module tb_mem_line_initiator;

    logic CLK = 1'b0;
    logic CLR = 1'b0;
    int   total = 0;
    int   bad   = 0;

    mem_line_initiator_if bus ();
    mem_line_initiator_if bus3 ();

    mem_line_initiator #(.ACCESS_CYCLES(4)) u_dut (
        .CLK (CLK),
        .CLR (CLR),
        .bus (bus)
    );

    mem_line_initiator #(.ACCESS_CYCLES(3)) u_dut3 (
        .CLK (CLK),
        .CLR (CLR),
        .bus (bus3)
    );

    always #5 CLK = ~CLK;

    localparam logic [127:0] DIN_A = 128'hDEADBEEF_00112233_44556677_8899AABB;
    localparam logic [127:0] DIN_B = 128'h55555555_66666666_77777777_88888888;
    localparam logic [127:0] WD_A  = 128'h01234567_89ABCDEF_0F1E2D3C_CAFEF00D;
    localparam logic [127:0] DIN_C = 128'hA5A5A5A5_5A5A5A5A_12345678_9ABCDEF0;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk11(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [10:0] exp_addr;
        logic        exp_ic;

        bus.IC_REQ = 1'b0;  bus.IC_ADDR = 11'h000;
        bus.DC_REQ = 1'b0;  bus.DC_WE = 1'b0; bus.DC_ADDR = 11'h000;
        bus.DC_BE = 16'h0000; bus.DC_WDATA = 128'h0; bus.MEM_DIN = 128'h0;
        bus3.IC_REQ = 1'b0; bus3.IC_ADDR = 11'h000;
        bus3.DC_REQ = 1'b0; bus3.DC_WE = 1'b0; bus3.DC_ADDR = 11'h000;
        bus3.DC_BE = 16'h0000; bus3.DC_WDATA = 128'h0; bus3.MEM_DIN = 128'h0;

        // Reset state
        tick();
        tick();
        chk1  ("rst_ic_ack", bus.IC_ACK,   1'b0);
        chk1  ("rst_dc_ack", bus.DC_ACK,   1'b0);
        chk1  ("rst_busy",   bus.BUSY,     1'b0);
        chk128("rst_rdata",  bus.RDATA,    128'h0);
        chk11 ("rst_mem_a",  bus.MEM_A,    11'h000);
        chk128("rst_dout",   bus.MEM_DOUT, 128'h0);
        chk1  ("rst_ce",     bus.MEM_CE,   1'b0);
        chk1  ("rst_oe_n",   bus.MEM_OE_N, 1'b1);
        chk16 ("rst_wr_n",   bus.MEM_WR_N, 16'hFFFF);
        CLR = 1'b1;
        tick();

        // ICACHE read: CE/OE for 4 cycles, ACK in the 5th cycle after accept
        bus.IC_REQ = 1'b1; bus.IC_ADDR = 11'h012; bus.MEM_DIN = DIN_A;
        tick();
        chk11("rd_mem_a", bus.MEM_A,    11'h012);
        chk1 ("rd_busy",  bus.BUSY,     1'b1);
        chk16("rd_wr_n",  bus.MEM_WR_N, 16'hFFFF);
        chk1 ("rd_ce0",   bus.MEM_CE,   1'b1);
        chk1 ("rd_oe0",   bus.MEM_OE_N, 1'b0);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk1("rd_ce",   bus.MEM_CE,   1'b1);
            chk1("rd_oe",   bus.MEM_OE_N, 1'b0);
            chk1("rd_noack", bus.IC_ACK,  1'b0);
        end
        tick();
        chk1  ("rd_ack",     bus.IC_ACK,   1'b1);
        chk1  ("rd_dc_ack",  bus.DC_ACK,   1'b0);
        chk1  ("rd_done_ce", bus.MEM_CE,   1'b0);
        chk1  ("rd_done_oe", bus.MEM_OE_N, 1'b1);
        chk128("rd_rdata",   bus.RDATA,    DIN_A);
        bus.IC_REQ = 1'b0;
        tick();
        chk1("rd_ack_end", bus.IC_ACK, 1'b0);
        chk1("rd_idle",    bus.BUSY,   1'b0);

        // DCACHE write BE=000F: strobes only at cnt 1 and 2, RDATA untouched
        bus.DC_REQ = 1'b1; bus.DC_WE = 1'b1; bus.DC_ADDR = 11'h7FF;
        bus.DC_BE = 16'h000F; bus.DC_WDATA = WD_A; bus.MEM_DIN = DIN_B;
        tick();
        chk11 ("wr_mem_a", bus.MEM_A,    11'h7FF);
        chk128("wr_dout",  bus.MEM_DOUT, WD_A);
        chk16 ("wr_wr_n0", bus.MEM_WR_N, 16'hFFFF);
        chk1  ("wr_oe0",   bus.MEM_OE_N, 1'b1);
        tick();
        chk16("wr_wr_n1", bus.MEM_WR_N, 16'hFFF0);
        chk1 ("wr_oe1",   bus.MEM_OE_N, 1'b1);
        tick();
        chk16("wr_wr_n2", bus.MEM_WR_N, 16'hFFF0);
        tick();
        chk16("wr_wr_n3", bus.MEM_WR_N, 16'hFFFF);
        chk1 ("wr_ce3",   bus.MEM_CE,   1'b1);
        tick();
        chk1  ("wr_ack",   bus.DC_ACK, 1'b1);
        chk1  ("wr_ic",    bus.IC_ACK, 1'b0);
        chk128("wr_rdata", bus.RDATA,  DIN_A);
        bus.DC_REQ = 1'b0;
        tick();
        chk1("wr_ack_end", bus.DC_ACK, 1'b0);

        // Both requests held: IC, DC, IC, DC with one idle cycle between
        bus.IC_REQ = 1'b1; bus.IC_ADDR = 11'h0A1;
        bus.DC_REQ = 1'b1; bus.DC_WE = 1'b0; bus.DC_ADDR = 11'h0B2;
        for (int t = 0; t < 4; t++) begin
            exp_ic   = (t % 2 == 0);
            exp_addr = exp_ic ? 11'h0A1 : 11'h0B2;
            tick();
            chk11("rr_mem_a", bus.MEM_A, exp_addr);
            for (int i = 1; i < 4; i++) begin
                tick();
            end
            tick();
            chk1("rr_ic_ack", bus.IC_ACK, exp_ic);
            chk1("rr_dc_ack", bus.DC_ACK, !exp_ic);
            tick();
            chk1("rr_gap_ic", bus.IC_ACK, 1'b0);
            chk1("rr_gap_dc", bus.DC_ACK, 1'b0);
            chk1("rr_gap_busy", bus.BUSY, 1'b0);
            chk1("rr_gap_ce", bus.MEM_CE, 1'b0);
        end
        bus.IC_REQ = 1'b0; bus.DC_REQ = 1'b0;
        tick();

        // Write with BE=0: no strobes, still acknowledged
        bus.DC_REQ = 1'b1; bus.DC_WE = 1'b1; bus.DC_ADDR = 11'h155; bus.DC_BE = 16'h0000;
        tick();
        chk16("be0_wr_n", bus.MEM_WR_N, 16'hFFFF);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk16("be0_wr_n", bus.MEM_WR_N, 16'hFFFF);
        end
        tick();
        chk1("be0_ack", bus.DC_ACK, 1'b1);
        bus.DC_REQ = 1'b0;
        tick();

        // Reset during cnt=2 of a write: strobes drop with no clock, no ACK
        bus.DC_REQ = 1'b1; bus.DC_WE = 1'b1; bus.DC_ADDR = 11'h0C3; bus.DC_BE = 16'hFF00;
        tick();
        tick();
        chk16("clr_wr_n1", bus.MEM_WR_N, 16'h00FF);
        tick();
        chk1("clr_ce2", bus.MEM_CE, 1'b1);
        #2;
        CLR = 1'b0;
        #1;
        chk1 ("clr_ce",   bus.MEM_CE,   1'b0);
        chk16("clr_wr_n", bus.MEM_WR_N, 16'hFFFF);
        chk1 ("clr_oe_n", bus.MEM_OE_N, 1'b1);
        chk1 ("clr_busy", bus.BUSY,     1'b0);
        tick();
        chk1("clr_no_ack", bus.DC_ACK, 1'b0);
        CLR = 1'b1;
        tick();
        chk1 ("clr_restart_ce", bus.MEM_CE, 1'b1);
        chk11("clr_restart_a",  bus.MEM_A,  11'h0C3);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk1("clr_restart_noack", bus.DC_ACK, 1'b0);
        end
        tick();
        chk1("clr_restart_ack", bus.DC_ACK, 1'b1);
        bus.DC_REQ = 1'b0;
        tick();

        // ACCESS_CYCLES=3 build: CE for 3 cycles, ACK in the 4th
        bus3.IC_REQ = 1'b1; bus3.IC_ADDR = 11'h03C; bus3.MEM_DIN = DIN_C;
        tick();
        chk1("ac3_ce0", bus3.MEM_CE, 1'b1);
        chk1("ac3_oe0", bus3.MEM_OE_N, 1'b0);
        for (int i = 1; i < 3; i++) begin
            tick();
            chk1("ac3_ce",    bus3.MEM_CE, 1'b1);
            chk1("ac3_noack", bus3.IC_ACK, 1'b0);
        end
        tick();
        chk1  ("ac3_ack",   bus3.IC_ACK, 1'b1);
        chk1  ("ac3_ce_off", bus3.MEM_CE, 1'b0);
        chk128("ac3_rdata", bus3.RDATA,  DIN_C);
        bus3.IC_REQ = 1'b0;
        tick();
        chk1("ac3_ack_end", bus3.IC_ACK, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
